button_cmd_arbiter: RTL

Collects single-cycle press pulses from the board's per-button debouncers and serialises them into one ordered command stream for the miner control FSM (start/stop, display page select, etc.). Each button has a one-deep pending latch; a round-robin arbiter moves pending presses into a small FIFO; the consumer drains the FIFO through a valid/ready handshake. Presses that arrive while the same button is already pending are coalesced and flagged.

---
 rtl/button_cmd_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/button_cmd_arbiter.sv
// button_cmd_arbiter: collects one-cycle button press pulses into per-button
// pending latches, picks one pending button per cycle round-robin, and queues
// its index in a small FIFO drained by the consumer via a valid/ready handshake.
// A press landing on an already-pending, not-granted button is coalesced and
// raises the sticky overflow flag.
module button_cmd_arbiter #(
    parameter int N_BTN      = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_BTN-1:0]              btn_down,
    input  logic                          cmd_ready,
    input  logic                          ovf_clr,
    output logic                          cmd_valid,
    output logic [ID_W-1:0]               cmd_id,
    output logic [N_BTN-1:0]              pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(N_BTN - 1);

    logic [ID_W-1:0]  rr_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ID_W-1:0]  fifo_mem [FIFO_DEPTH];

    logic [N_BTN-1:0] hi_req;
    logic [N_BTN-1:0] req;
    logic [N_BTN-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             coalesce;

    assign fifo_full = (fifo_count == FULL_COUNT);
    assign push      = |grant;
    assign pop       = cmd_valid & cmd_ready;
    assign coalesce  = |(btn_down & pending & ~grant);

    // Round-robin pick: prefer pending bits at or above rr_ptr, else wrap to the lowest pending bit.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        hi_req   = '0;
        grant    = '0;
        grant_id = '0;
        for (int i = 0; i < N_BTN; i++) begin
            hi_req[i] = pending[i] && (ID_W'(i) >= rr_ptr);
        end
        req = (hi_req != '0) ? hi_req : pending;
        if (!fifo_full) begin
            // Scanning downward leaves the lowest set bit as the final winner.
            for (int i = N_BTN - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    grant_id = ID_W'(i);
                end
            end
        end
    end

    // Pending latches, sticky overflow and the round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            pending <= (pending & ~grant) | btn_down;
            if (coalesce) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (push) begin
                rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale entries are never visible because cmd_id is masked by cmd_valid.
        if (push) begin
            fifo_mem[wr_ptr] <= grant_id;
        end
    end

    assign cmd_valid = (fifo_count != '0);
    assign cmd_id    = cmd_valid ? fifo_mem[rd_ptr] : '0;

endmodule
